// File: rtl/snn_cfg_scheduler_pkg.sv
// Shared types for the snn_layer configuration scheduler: word width, fixed-point
// helper, configuration kind and scheduler FSM state encodings.
`ifndef W
`define W 16
`endif

package snn_cfg_scheduler_pkg;

   localparam int FX_FRAC = 8;

   typedef enum logic {
      CFG_WEIGHT = 1'b0,
      CFG_DELAY  = 1'b1
   } cfg_kind_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      QUIESCE = 2'd1,
      LOAD    = 2'd2
   } sched_state_e;

   // Real-to-fixed conversion with round-half-away-from-zero; constant use only.
   function automatic logic signed [`W-1:0] fx(input real v);
      real scaled;
      scaled = v * (2.0 ** FX_FRAC);
      if (scaled >= 0.0) begin
         return `W'($rtoi(scaled + 0.5));
      end else begin
         return `W'($rtoi(scaled - 0.5));
      end
   endfunction

endpackage

// File: rtl/snn_cfg_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches from the stored pointer, which moves past the
// winner whenever the owner accepts a grant.
module rr_arbiter #(
   parameter  int NUM_REQ = 2,
   localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant_onehot,
   output logic [IDX_W-1:0]   grant_idx
);

   logic [IDX_W-1:0]   ptr_r;
   logic [NUM_REQ-1:0] rot_s;
   logic [NUM_REQ-1:0] onehot_s;
   logic [IDX_W-1:0]   idx_s;
   logic               found_s;
   int                 cand_s;

   // Rotate requests so bit 0 is the pointer position, then take the first set bit.
   always_comb begin
      found_s  = 1'b0;
      idx_s    = '0;
      cand_s   = 0;
      onehot_s = '0;
      rot_s    = NUM_REQ'({req, req} >> ptr_r);
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!found_s && rot_s[j]) begin
            found_s = 1'b1;
            cand_s  = int'(ptr_r) + j;
            if (cand_s >= NUM_REQ) begin
               cand_s = cand_s - NUM_REQ;
            end else begin
               cand_s = cand_s;
            end
            idx_s = IDX_W'(cand_s);
         end else begin
            found_s = found_s;
         end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
         onehot_s[k] = found_s && (idx_s == IDX_W'(k));
      end
   end

   // Pointer register: moves to winner+1 (mod NUM_REQ) on an accepted grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_r <= '0;
      end else if (advance) begin
         if (idx_s == IDX_W'(NUM_REQ - 1)) begin
            ptr_r <= '0;
         end else begin
            ptr_r <= idx_s + IDX_W'(1);
         end
      end else begin
         ptr_r <= ptr_r;
      end
   end

   assign grant_onehot = onehot_s;
   assign grant_idx    = idx_s;

endmodule

// File: rtl/snn_cfg_scheduler.sv
// Sequences weight/delay configuration bursts from several requesters into the
// snn_layer cfg port, holding the layer quiet while in-flight spikes drain.
module snn_cfg_scheduler
   import snn_cfg_scheduler_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int NUM_INPUTS  = 32,
   parameter int NUM_NEURONS = 1,
   parameter int MAX_DELAY   = 4,
   parameter int LEN_W       = 16,
   parameter int ADDR_W      = ((NUM_INPUTS * NUM_NEURONS) > 1) ?
                               $clog2(NUM_INPUTS * NUM_NEURONS) : 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ-1:0]             req_kind,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_base,
   input  logic [NUM_REQ-1:0][LEN_W-1:0]  req_len,
   input  logic [NUM_REQ-1:0]             dat_valid,
   output logic [NUM_REQ-1:0]             dat_ready,
   input  logic [NUM_REQ-1:0][`W-1:0]     dat_wdata,
   input  logic [NUM_REQ-1:0][7:0]        dat_delay,
   output logic                           cfg_we,
   output logic                           cfg_sel_delay,
   output logic [ADDR_W-1:0]              cfg_addr,
   output logic signed [`W-1:0]           cfg_wdata,
   output logic [7:0]                     cfg_delay,
   output logic                           layer_hold,
   output logic                           busy,
   output logic                           done,
   output logic                           err
);

   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TOTAL  = NUM_INPUTS * NUM_NEURONS;
   localparam int SUM_W  = LEN_W + 1;
   localparam int QCNT_W = (MAX_DELAY > 0) ? $clog2(MAX_DELAY + 1) : 1;

   sched_state_e         state_r, state_n_s;
   cfg_kind_e            kind_r;
   logic [IDX_W-1:0]     gnt_r;
   logic [ADDR_W-1:0]    base_r;
   logic [LEN_W-1:0]     len_r;
   logic [LEN_W-1:0]     idx_r;
   logic [QCNT_W-1:0]    qcnt_r;

   logic                 cfg_we_r, sel_r, done_r, err_r;
   logic [ADDR_W-1:0]    addr_r;
   logic signed [`W-1:0] wdata_r;
   logic [7:0]           delay_r;

   logic [NUM_REQ-1:0]   arb_onehot_s;
   logic [IDX_W-1:0]     arb_idx_s;
   logic [NUM_REQ-1:0]   req_ready_s, dat_ready_s;
   logic [SUM_W-1:0]     sum_s;
   logic                 grant_s, reject_s, hs_s, last_s;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .clk          (clk),
      .rst          (rst),
      .req          (req_valid),
      .advance      (grant_s),
      .grant_onehot (arb_onehot_s),
      .grant_idx    (arb_idx_s)
   );

   // Next-state and handshake decode; no grant in the done cycle.
   always_comb begin
      state_n_s   = state_r;
      grant_s     = 1'b0;
      reject_s    = 1'b0;
      hs_s        = 1'b0;
      last_s      = 1'b0;
      req_ready_s = '0;
      dat_ready_s = '0;
      sum_s       = SUM_W'(req_base[arb_idx_s]) + SUM_W'(req_len[arb_idx_s]);
      case (state_r)
         IDLE: begin
            if (!done_r && (|req_valid)) begin
               grant_s     = 1'b1;
               req_ready_s = arb_onehot_s;
               if ((req_len[arb_idx_s] == '0) || (sum_s > SUM_W'(TOTAL))) begin
                  reject_s  = 1'b1;
                  state_n_s = IDLE;
               end else begin
                  state_n_s = QUIESCE;
               end
            end else begin
               state_n_s = IDLE;
            end
         end
         QUIESCE: begin
            if (qcnt_r == QCNT_W'(MAX_DELAY)) begin
               state_n_s = LOAD;
            end else begin
               state_n_s = QUIESCE;
            end
         end
         LOAD: begin
            dat_ready_s[gnt_r] = 1'b1;
            hs_s               = dat_valid[gnt_r];
            if (hs_s && (idx_r == (len_r - LEN_W'(1)))) begin
               last_s    = 1'b1;
               state_n_s = IDLE;
            end else begin
               state_n_s = LOAD;
            end
         end
         default: begin
            state_n_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_n_s;
      end
   end

   // Descriptor latch, quiesce/word counters and registered cfg outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         kind_r   <= CFG_WEIGHT;
         gnt_r    <= '0;
         base_r   <= '0;
         len_r    <= '0;
         idx_r    <= '0;
         qcnt_r   <= '0;
         cfg_we_r <= 1'b0;
         sel_r    <= 1'b0;
         addr_r   <= '0;
         wdata_r  <= '0;
         delay_r  <= '0;
         done_r   <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         err_r    <= reject_s;
         done_r   <= last_s;
         cfg_we_r <= hs_s;
         if (grant_s) begin
            kind_r <= cfg_kind_e'(req_kind[arb_idx_s]);
            gnt_r  <= arb_idx_s;
            base_r <= req_base[arb_idx_s];
            len_r  <= req_len[arb_idx_s];
         end else begin
            kind_r <= kind_r;
            gnt_r  <= gnt_r;
            base_r <= base_r;
            len_r  <= len_r;
         end
         if ((state_r == QUIESCE) && (state_n_s == QUIESCE)) begin
            qcnt_r <= qcnt_r + QCNT_W'(1);
         end else begin
            qcnt_r <= '0;
         end
         if (grant_s) begin
            idx_r <= '0;
         end else if (hs_s) begin
            idx_r <= idx_r + LEN_W'(1);
         end else begin
            idx_r <= idx_r;
         end
         // The field not selected by kind is forced to zero on each write.
         if (hs_s) begin
            sel_r   <= kind_r;
            addr_r  <= base_r + ADDR_W'(idx_r);
            wdata_r <= (kind_r == CFG_WEIGHT) ? dat_wdata[gnt_r] : '0;
            delay_r <= (kind_r == CFG_DELAY) ? dat_delay[gnt_r] : 8'd0;
         end else begin
            sel_r   <= sel_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
            delay_r <= delay_r;
         end
      end
   end

   assign req_ready     = req_ready_s;
   assign dat_ready     = dat_ready_s;
   assign cfg_we        = cfg_we_r;
   assign cfg_sel_delay = sel_r;
   assign cfg_addr      = addr_r;
   assign cfg_wdata     = wdata_r;
   assign cfg_delay     = delay_r;
   assign layer_hold    = (state_r != IDLE);
   assign busy          = (state_r != IDLE);
   assign done          = done_r;
   assign err           = err_r;

endmodule

// File: tb/tb_snn_cfg_scheduler.sv
// Directed bench for snn_cfg_scheduler: hand-computed expectations checked with
// immediate assertions, one linear stimulus sequence.
`timescale 1ns/1ps
module tb_snn_cfg_scheduler;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       req_valid, req_ready, req_kind;
   logic [1:0][4:0]  req_base;
   logic [1:0][15:0] req_len;
   logic [1:0]       dat_valid, dat_ready;
   logic [1:0][15:0] dat_wdata;
   logic [1:0][7:0]  dat_delay;
   logic             cfg_we, cfg_sel_delay;
   logic [4:0]       cfg_addr;
   logic [15:0]      cfg_wdata;
   logic [7:0]       cfg_delay;
   logic             layer_hold, busy, done, err;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   snn_cfg_scheduler dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_kind      (req_kind),
      .req_base      (req_base),
      .req_len       (req_len),
      .dat_valid     (dat_valid),
      .dat_ready     (dat_ready),
      .dat_wdata     (dat_wdata),
      .dat_delay     (dat_delay),
      .cfg_we        (cfg_we),
      .cfg_sel_delay (cfg_sel_delay),
      .cfg_addr      (cfg_addr),
      .cfg_wdata     (cfg_wdata),
      .cfg_delay     (cfg_delay),
      .layer_hold    (layer_hold),
      .busy          (busy),
      .done          (done),
      .err           (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Five quiesce cycles with hold high, no writes, no handshakes offered.
   task automatic quiesce(input string tag);
      for (int i = 0; i < 5; i++) begin
         chk({tag, "_hold"}, 32'(layer_hold), 32'd1);
         chk({tag, "_qwe"}, 32'(cfg_we), 32'd0);
         chk({tag, "_qdrdy"}, 32'(dat_ready), 32'd0);
         chk({tag, "_qrrdy"}, 32'(req_ready), 32'd0);
         tick();
      end
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_we"}, 32'(cfg_we), 32'd0);
      chk({tag, "_sel"}, 32'(cfg_sel_delay), 32'd0);
      chk({tag, "_addr"}, 32'(cfg_addr), 32'd0);
      chk({tag, "_wdata"}, 32'(cfg_wdata), 32'd0);
      chk({tag, "_delay"}, 32'(cfg_delay), 32'd0);
      chk({tag, "_hold"}, 32'(layer_hold), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_drdy"}, 32'(dat_ready), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 2'b00; req_kind = 2'b00; req_base = '0; req_len = '0;
      dat_valid = 2'b00; dat_wdata = '0; dat_delay = '0;
      tick(); tick();
      chk_idle_zero("rst0");
      rst = 1'b0;
      tick();

      // 1: req0 weight burst base 4, len 3, FX(0.1)=26, FX(0.2)=51, FX(0.3)=77
      req_kind[0] = 1'b0; req_base[0] = 5'd4; req_len[0] = 16'd3; req_valid[0] = 1'b1;
      dat_valid[0] = 1'b1; dat_wdata[0] = 16'd26;
      #1;
      chk("t1_rrdy", 32'(req_ready), 32'd1);
      tick(); req_valid[0] = 1'b0;
      chk("t1_busy", 32'(busy), 32'd1);
      quiesce("t1");
      chk("t1_drdy", 32'(dat_ready), 32'd1);
      tick();
      chk("t1_we0", 32'(cfg_we), 32'd1);
      chk("t1_addr0", 32'(cfg_addr), 32'd4);
      chk("t1_wd0", 32'(cfg_wdata), 32'd26);
      chk("t1_sel0", 32'(cfg_sel_delay), 32'd0);
      chk("t1_done0", 32'(done), 32'd0);
      dat_wdata[0] = 16'd51;
      tick();
      chk("t1_addr1", 32'(cfg_addr), 32'd5);
      chk("t1_wd1", 32'(cfg_wdata), 32'd51);
      dat_wdata[0] = 16'd77;
      tick();
      chk("t1_we2", 32'(cfg_we), 32'd1);
      chk("t1_addr2", 32'(cfg_addr), 32'd6);
      chk("t1_wd2", 32'(cfg_wdata), 32'd77);
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_hold_end", 32'(layer_hold), 32'd0);
      chk("t1_busy_end", 32'(busy), 32'd0);
      chk("t1_drdy_end", 32'(dat_ready), 32'd0);
      dat_valid[0] = 1'b0;
      tick();
      chk("t1_we_after", 32'(cfg_we), 32'd0);
      chk("t1_done_after", 32'(done), 32'd0);
      chk("t1_addr_keep", 32'(cfg_addr), 32'd6);

      // 2: req1 delay burst base 0, len 2, delays 2 and 3
      req_kind[1] = 1'b1; req_base[1] = 5'd0; req_len[1] = 16'd2; req_valid[1] = 1'b1;
      dat_valid[1] = 1'b1; dat_delay[1] = 8'd2; dat_wdata[1] = 16'h7fff;
      #1;
      chk("t2_rrdy", 32'(req_ready), 32'd2);
      tick(); req_valid[1] = 1'b0;
      quiesce("t2");
      chk("t2_drdy", 32'(dat_ready), 32'd2);
      tick();
      chk("t2_we0", 32'(cfg_we), 32'd1);
      chk("t2_sel0", 32'(cfg_sel_delay), 32'd1);
      chk("t2_addr0", 32'(cfg_addr), 32'd0);
      chk("t2_dly0", 32'(cfg_delay), 32'd2);
      chk("t2_wd0", 32'(cfg_wdata), 32'd0);
      dat_delay[1] = 8'd3;
      tick();
      chk("t2_addr1", 32'(cfg_addr), 32'd1);
      chk("t2_dly1", 32'(cfg_delay), 32'd3);
      chk("t2_done", 32'(done), 32'd1);
      dat_valid[1] = 1'b0;
      tick();

      rst = 1'b1;
      tick();
      chk_idle_zero("rst1");
      rst = 1'b0;
      tick();

      // 3a: both requesters from reset -> req0 then req1, one idle cycle after done
      req_kind = 2'b00; req_base[0] = 5'd8; req_base[1] = 5'd9;
      req_len[0] = 16'd1; req_len[1] = 16'd1; req_valid = 2'b11;
      dat_valid = 2'b11; dat_wdata[0] = 16'd100; dat_wdata[1] = 16'd200;
      #1;
      chk("t3a_rrdy0", 32'(req_ready), 32'd1);
      tick(); req_valid[0] = 1'b0;
      quiesce("t3a0");
      chk("t3a_drdy0", 32'(dat_ready), 32'd1);
      tick();
      chk("t3a_addr0", 32'(cfg_addr), 32'd8);
      chk("t3a_wd0", 32'(cfg_wdata), 32'd100);
      chk("t3a_done0", 32'(done), 32'd1);
      chk("t3a_nogrant_done", 32'(req_ready), 32'd0);
      tick();
      chk("t3a_rrdy1", 32'(req_ready), 32'd2);
      tick(); req_valid[1] = 1'b0;
      quiesce("t3a1");
      chk("t3a_drdy1", 32'(dat_ready), 32'd2);
      tick();
      chk("t3a_addr1", 32'(cfg_addr), 32'd9);
      chk("t3a_wd1", 32'(cfg_wdata), 32'd200);
      chk("t3a_done1", 32'(done), 32'd1);
      dat_valid = 2'b00;
      tick();

      // 5: rejected descriptors (overrun, zero length); pointer moves past req0
      req_base[0] = 5'd30; req_len[0] = 16'd3; req_valid[0] = 1'b1;
      #1;
      chk("t5_rrdy", 32'(req_ready), 32'd1);
      tick(); req_valid[0] = 1'b0;
      chk("t5_err", 32'(err), 32'd1);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_hold", 32'(layer_hold), 32'd0);
      chk("t5_we", 32'(cfg_we), 32'd0);
      tick();
      chk("t5_err_pulse", 32'(err), 32'd0);
      chk("t5_busy2", 32'(busy), 32'd0);
      req_base[0] = 5'd0; req_len[0] = 16'd0; req_valid[0] = 1'b1;
      #1;
      chk("t5_rrdy_len0", 32'(req_ready), 32'd1);
      tick(); req_valid[0] = 1'b0;
      chk("t5_err_len0", 32'(err), 32'd1);
      chk("t5_busy_len0", 32'(busy), 32'd0);
      tick();
      chk("t5_err_len0_pulse", 32'(err), 32'd0);
      chk("t5_we_len0", 32'(cfg_we), 32'd0);

      // 3b: pointer now at req1 -> req1 then req0
      req_base[0] = 5'd10; req_base[1] = 5'd11; req_len[0] = 16'd1; req_len[1] = 16'd1;
      req_valid = 2'b11; dat_valid = 2'b11; dat_wdata[0] = 16'd300; dat_wdata[1] = 16'd400;
      #1;
      chk("t3b_rrdy1", 32'(req_ready), 32'd2);
      tick(); req_valid[1] = 1'b0;
      quiesce("t3b1");
      chk("t3b_drdy1", 32'(dat_ready), 32'd2);
      tick();
      chk("t3b_addr1", 32'(cfg_addr), 32'd11);
      chk("t3b_wd1", 32'(cfg_wdata), 32'd400);
      chk("t3b_done1", 32'(done), 32'd1);
      chk("t3b_nogrant_done", 32'(req_ready), 32'd0);
      tick();
      chk("t3b_rrdy0", 32'(req_ready), 32'd1);
      tick(); req_valid[0] = 1'b0;
      quiesce("t3b0");
      tick();
      chk("t3b_addr0", 32'(cfg_addr), 32'd10);
      chk("t3b_wd0", 32'(cfg_wdata), 32'd300);
      chk("t3b_done0", 32'(done), 32'd1);
      dat_valid = 2'b00;
      tick();

      // 4: gapped data stream, len 2
      req_base[0] = 5'd2; req_len[0] = 16'd2; req_valid[0] = 1'b1;
      dat_valid[0] = 1'b1; dat_wdata[0] = 16'd5;
      #1;
      chk("t4_rrdy", 32'(req_ready), 32'd1);
      tick(); req_valid[0] = 1'b0;
      quiesce("t4");
      tick();
      chk("t4_we0", 32'(cfg_we), 32'd1);
      chk("t4_addr0", 32'(cfg_addr), 32'd2);
      chk("t4_wd0", 32'(cfg_wdata), 32'd5);
      dat_valid[0] = 1'b0;
      tick();
      chk("t4_gap_we", 32'(cfg_we), 32'd0);
      chk("t4_gap_addr", 32'(cfg_addr), 32'd2);
      chk("t4_gap_wd", 32'(cfg_wdata), 32'd5);
      chk("t4_gap_done", 32'(done), 32'd0);
      chk("t4_gap_hold", 32'(layer_hold), 32'd1);
      chk("t4_gap_drdy", 32'(dat_ready), 32'd1);
      dat_valid[0] = 1'b1; dat_wdata[0] = 16'd6;
      tick();
      chk("t4_we1", 32'(cfg_we), 32'd1);
      chk("t4_addr1", 32'(cfg_addr), 32'd3);
      chk("t4_wd1", 32'(cfg_wdata), 32'd6);
      chk("t4_done", 32'(done), 32'd1);
      dat_valid[0] = 1'b0;
      tick();
      chk("t4_we_after", 32'(cfg_we), 32'd0);

      // 6: reset on the second handshake of a len-4 burst ending exactly at 32
      req_base[0] = 5'd28; req_len[0] = 16'd4; req_valid[0] = 1'b1;
      dat_valid[0] = 1'b1; dat_wdata[0] = 16'd1;
      #1;
      chk("t6_rrdy", 32'(req_ready), 32'd1);
      tick(); req_valid[0] = 1'b0;
      chk("t6_no_err", 32'(err), 32'd0);
      chk("t6_busy", 32'(busy), 32'd1);
      quiesce("t6");
      tick();
      chk("t6_we0", 32'(cfg_we), 32'd1);
      chk("t6_addr0", 32'(cfg_addr), 32'd28);
      chk("t6_wd0", 32'(cfg_wdata), 32'd1);
      dat_wdata[0] = 16'd2; rst = 1'b1;
      tick();
      chk_idle_zero("t6_rst");
      rst = 1'b0; dat_valid[0] = 1'b0;
      tick();
      chk("t6_post_we", 32'(cfg_we), 32'd0);
      chk("t6_post_busy", 32'(busy), 32'd0);
      chk("t6_post_done", 32'(done), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
